timer_share_ctrl: RTL

Round-robin scheduler that shares one external autoreset counter among `N_REQ` requesters, each asking for a timed interval of `limit+1` counted cycles. It arbitrates requests and latches the winner's limit. It then sequences the counter's `rst`/`en`/`autoreset_limit` inputs, watches its `value`, and returns a one-cycle `done` pulse tagged with the requester id. It sits between client FSMs and the shared 8-bit counter in the lab datapath.

---
 rtl/timer_share_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/timer_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : timer_share_ctrl
// Purpose  : Round-robin scheduler sharing one external autoreset counter
//            among N_REQ requesters. The winner's limit is latched, the
//            counter is cleared, run until value == limit, and a one-cycle
//            done pulse tagged with the requester id is returned.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   N_REQ        number of requesters (2..8)
//   W            counter / limit width, must match the counter instance
// Ports
//   clk          clock, all state updates on posedge
//   rst          synchronous active-high reset
//   req_i        level request per requester, held until its done
//   req_limit_i  flattened limits, requester i at [i*W +: W]
//   grant_o      one-hot current owner of the counter, 0 when free
//   busy_o       counter owned
//   done_o       one-cycle pulse, interval finished
//   done_id_o    id of finished requester, holds between pulses
//   cnt_rst_o    to counter rst
//   cnt_en_o     to counter en
//   cnt_limit_o  to counter autoreset_limit
//   cnt_value_i  from counter value
// Build option
//   TSC_ABORT_EN defined: dropping the owner's request during LOAD/RUN
//   aborts the interval (no done) and clears the counter for one cycle.
// ============================================================================
module timer_share_ctrl #(
    parameter int N_REQ = 4,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_i,
    input  logic [N_REQ*W-1:0]         req_limit_i,
    output logic [N_REQ-1:0]           grant_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [$clog2(N_REQ)-1:0]   done_id_o,
    output logic                       cnt_rst_o,
    output logic                       cnt_en_o,
    output logic [W-1:0]               cnt_limit_o,
    input  logic [W-1:0]               cnt_value_i
);

    localparam int IDW = $clog2(N_REQ);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_LOAD = 2'd1;
    localparam logic [1:0] c_RUN  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    localparam logic [IDW:0] c_NREQ = (IDW+1)'(N_REQ);

    logic [1:0]     state_q,   state_d;
    logic [IDW-1:0] ptr_q,     ptr_d;
    logic [IDW-1:0] id_q,      id_d;
    logic [IDW-1:0] done_id_q, done_id_d;
    logic [W-1:0]   lim_q,     lim_d;
    logic           abort_q,   abort_d;

    logic [2*N_REQ-1:0] w_req2;
    logic [N_REQ-1:0]   w_rot;
    logic [IDW:0]       w_sum;
    logic [IDW-1:0]     w_pick;
    logic [W-1:0]       w_pick_lim;
    logic               w_found;
    logic [IDW:0]       w_inc;
    logic [IDW-1:0]     w_ptr_next;
    logic [N_REQ-1:0]   w_onehot;
    logic               w_abort;

    // Rotate the request vector so bit 0 corresponds to requester ptr;
    // the lowest set bit of the rotated vector is then the round-robin winner.
    assign w_req2 = {req_i, req_i};
    assign w_rot  = N_REQ'(w_req2 >> ptr_q);
    assign w_found = |req_i;

    always_comb begin
        w_sum = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_sum = {1'b0, ptr_q} + (IDW+1)'(k);
            end
        end
        if (w_sum >= c_NREQ) begin
            w_sum = w_sum - c_NREQ;
        end
        w_pick = w_sum[IDW-1:0];
    end

    always_comb begin
        w_pick_lim = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_pick == IDW'(i)) begin
                w_pick_lim = req_limit_i[i*W +: W];
            end
        end
    end

    // (id + 1) mod N_REQ, valid for non-power-of-two N_REQ too
    assign w_inc      = {1'b0, id_q} + (IDW+1)'(1);
    assign w_ptr_next = (w_inc == c_NREQ) ? '0 : w_inc[IDW-1:0];

    assign w_onehot = N_REQ'(1) << id_q;

`ifdef TSC_ABORT_EN
    logic w_req_own;
    assign w_req_own = |(req_i & w_onehot);
    assign w_abort   = ((state_q == c_LOAD) || (state_q == c_RUN)) && !w_req_own;
`else
    assign w_abort   = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= c_IDLE;
            ptr_q     <= '0;
            id_q      <= '0;
            done_id_q <= '0;
            lim_q     <= '0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
            done_id_q <= done_id_d;
            lim_q     <= lim_d;
            abort_q   <= abort_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        done_id_d = done_id_q;
        lim_d     = lim_q;
        abort_d   = 1'b0;
        case (state_q)
            c_IDLE: begin
                if (w_found) begin
                    state_d = c_LOAD;
                    id_d    = w_pick;
                    lim_d   = w_pick_lim;
                end
            end
            c_LOAD: begin
                if (w_abort) begin
                    state_d = c_IDLE;
                    ptr_d   = w_ptr_next;
                    abort_d = 1'b1;
                end else begin
                    state_d = c_RUN;
                end
            end
            c_RUN: begin
                if (w_abort) begin
                    state_d = c_IDLE;
                    ptr_d   = w_ptr_next;
                    abort_d = 1'b1;
                end else if (cnt_value_i == lim_q) begin
                    // Counter autoresets at this same edge.
                    state_d   = c_DONE;
                    done_id_d = id_q;
                end
            end
            c_DONE: begin
                state_d = c_IDLE;
                ptr_d   = w_ptr_next;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        grant_o     = '0;
        done_o      = 1'b0;
        cnt_en_o    = 1'b0;
        cnt_limit_o = '1;
        // rst is passed straight through so the counter clears with us;
        // abort_q clears it in the IDLE cycle after an aborted interval.
        cnt_rst_o   = rst | (state_q == c_LOAD) | abort_q;
        if (state_q != c_IDLE) begin
            grant_o     = w_onehot;
            cnt_limit_o = lim_q;
        end
        if (state_q == c_RUN) begin
            cnt_en_o = 1'b1;
        end
        if (state_q == c_DONE) begin
            done_o = 1'b1;
        end
    end

    assign busy_o    = |grant_o;
    assign done_id_o = done_id_q;

endmodule
`default_nettype wire
